program_loader: RTL and testbench

- Byte-stream boot loader that sits directly upstream of the single-cycle processor.
- Receives a framed program over a byte valid/ready interface and assembles 32-bit instructions big-endian.
- Writes the instructions into the instruction memory at word addresses.
- Holds the core in reset until a frame with a good checksum has fully loaded, then releases it.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/loader_word_packer.sv | 45 ++++
 rtl/program_loader.sv | 179 +++++++++++++++++
 tb/tb_program_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream program loader: field widths,
// the default frame-start byte and the loader FSM state encoding.
package loader_pkg;

  localparam int BYTE_W = 8;   // width of one stream byte
  localparam int LEN_W  = 16;  // width of the frame length field
  localparam int WORD_W = 32;  // width of one assembled instruction word

  localparam logic [BYTE_W-1:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_e;

endpackage

// File: rtl/loader_word_packer.sv
// Byte-to-word packer for the program loader. Shifts accepted data bytes
// MSB first into a 32-bit word, counts bytes within the current word and
// keeps the running XOR checksum of every byte it is told to fold in.
module loader_word_packer
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,     // start of a new frame
  input  logic              csum_en_i,   // fold byte_i into the checksum
  input  logic              shift_en_i,  // shift byte_i into the word
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_next_o, // word including byte_i
  output logic [BYTE_W-1:0] csum_o,
  output logic              word_full_o  // byte_i completes the word
);

  logic [WORD_W-1:0] word_q;
  logic [1:0]        cnt_q;
  logic [BYTE_W-1:0] csum_q;

  assign word_next_o = {word_q[WORD_W-BYTE_W-1:0], byte_i};
  assign word_full_o = shift_en_i && (cnt_q == 2'd3);
  assign csum_o      = csum_q;

  // Shift register, byte-in-word counter and running checksum.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i || clear_i) begin
      word_q <= '0;
      cnt_q  <= '0;
      csum_q <= '0;
    end else begin
      if (csum_en_i) begin
        csum_q <= csum_q ^ byte_i;
      end
      if (shift_en_i) begin
        word_q <= word_next_o;
        cnt_q  <= cnt_q + 2'd1;  // wraps 3 -> 0 at each full word
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader in front of the single-cycle core. Accepts a framed program
// (MAGIC, LEN_HI, LEN_LO, LEN big-endian words, CSUM) on a byte
// valid/ready port, writes the words to instruction memory and holds the
// core in reset until a frame with a matching checksum has fully loaded.
module program_loader
  import loader_pkg::*;
#(
  parameter int                  WL        = 32,
  parameter int                  DEPTH     = 256,
  parameter logic [WL-1:0]       LOAD_BASE = '0,
  parameter logic [BYTE_W-1:0]   MAGIC     = MAGIC_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          im_we,
  output logic [WL-1:0] im_addr,
  output logic [WL-1:0] im_wdata,
  output logic          core_rst,
  output logic          done,
  output logic          error
);

  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [WL-1:0]    ADDR_ONE = WL'(1);

  state_e            state_q;
  logic              rx_ready_q;
  logic              im_we_q;
  logic [WL-1:0]     im_addr_q;
  logic [WL-1:0]     im_wdata_q;
  logic              core_rst_q;
  logic              done_q;
  logic              error_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;

  logic              rx_fire;
  logic              is_magic;
  logic              frame_start;
  logic              csum_en;
  logic              shift_en;
  logic [LEN_W-1:0]  len_d;
  logic [LEN_W-1:0]  count_d;
  logic [WORD_W-1:0] word_next;
  logic [BYTE_W-1:0] csum;
  logic              word_full;

  assign rx_fire  = rx_valid && rx_ready_q;
  assign is_magic = (rx_data == MAGIC);
  assign len_d    = {len_q[LEN_W-1:BYTE_W], rx_data};
  assign count_d  = count_q + LEN_W'(1);

  // Packer control: MAGIC in a resting state opens a frame; length and
  // data bytes feed the checksum; only data bytes build words.
  always_comb begin
    frame_start = 1'b0;
    csum_en     = 1'b0;
    shift_en    = 1'b0;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERROR: frame_start = rx_fire && is_magic;
      S_LEN_HI, S_LEN_LO:     csum_en     = rx_fire;
      S_DATA: begin
        csum_en  = rx_fire;
        shift_en = rx_fire;
      end
      default: ;
    endcase
  end

  loader_word_packer u_packer (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clear_i     (frame_start),
    .csum_en_i   (csum_en),
    .shift_en_i  (shift_en),
    .byte_i      (rx_data),
    .word_next_o (word_next),
    .csum_o      (csum),
    .word_full_o (word_full)
  );

  // Loader FSM with registered outputs; a stalled byte leaves everything held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b1;
      im_we_q    <= 1'b0;
      im_addr_q  <= LOAD_BASE;
      im_wdata_q <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      len_q      <= '0;
      count_q    <= '0;
    end else begin
      // WRITE is the only state that drops ready or raises the write strobe,
      // and it always lasts one cycle, so these defaults undo it.
      rx_ready_q <= 1'b1;
      im_we_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_fire && is_magic) state_q <= S_LEN_HI;
        end
        S_LEN_HI: begin
          if (rx_fire) begin
            len_q   <= {rx_data, len_q[BYTE_W-1:0]};
            state_q <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (rx_fire) begin
            len_q <= len_d;
            if (len_d == '0) begin
              state_q <= S_CHECK;
            end else if (len_d > DEPTH_L) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else begin
              state_q   <= S_DATA;
              im_addr_q <= LOAD_BASE;
              count_q   <= '0;
            end
          end
        end
        S_DATA: begin
          if (word_full) begin
            state_q    <= S_WRITE;
            im_we_q    <= 1'b1;
            rx_ready_q <= 1'b0;
            im_wdata_q <= WL'(word_next);
          end
        end
        S_WRITE: begin
          im_addr_q <= im_addr_q + ADDR_ONE;
          count_q   <= count_d;
          state_q   <= (count_d == len_q) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (rx_fire) begin
            if (rx_data == csum) begin
              state_q    <= S_RUN;
              core_rst_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (rx_fire && is_magic) begin
            state_q    <= S_LEN_HI;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_ERROR: begin
          if (rx_fire && is_magic) begin
            state_q <= S_LEN_HI;
            error_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a table of whole frames with their
// expected writes and final status, plus hand sequences for latency,
// stalls, reload and mid-frame reset.
module tb_program_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          ready_low = 0;

  program_loader dut (
    .CLK      (CLK),
    .RST      (RST),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 CLK = ~CLK;

  // Write and back-pressure monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
    end
    if (!rx_ready) ready_low++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Offer one byte from a negedge, wait (bounded) for ready, return at the
  // negedge after the transfer edge with rx_valid dropped.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    ready_low = 0;
  endtask

  task automatic check_status(input string tag, input logic crst, input logic dn, input logic er);
    check({tag, "_core_rst"}, 32'(core_rst), 32'(crst));
    check({tag, "_done"},     32'(done),     32'(dn));
    check({tag, "_error"},    32'(error),    32'(er));
  endtask

  typedef struct {
    string       name;
    int          first;
    int          n;
    int          exp_wr;
    logic [31:0] a0, d0, a1, d1;
    logic        crst, dn, er;
  } vec_t;

  logic [7:0] stim[$];
  vec_t       vecs[6];
  logic [7:0] good[12];

  initial begin
    RST      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Checksums: 00^02^20^08^00^05^01^09^50^20 = 57; 00^01^AA^BB^CC^DD = 01.
    stim = '{
      8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h57,
      8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h00,
      8'hA5, 8'h01, 8'h01,
      8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h57,
      8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01,
      8'hA5, 8'h00, 8'h00, 8'h00
    };
    vecs[0] = '{"good2",     0, 12, 2, 32'd0, 32'h20080005, 32'd1, 32'h01095020, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"badcsum",  12, 12, 2, 32'd0, 32'h20080005, 32'd1, 32'h01095020, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"oversize", 24,  3, 0, 32'd0, 32'd0,        32'd0, 32'd0,        1'b1, 1'b0, 1'b1};
    vecs[3] = '{"recover",  27, 12, 2, 32'd0, 32'h20080005, 32'd1, 32'h01095020, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"reload1",  39,  8, 1, 32'd0, 32'hAABBCCDD, 32'd0, 32'd0,        1'b0, 1'b1, 1'b0};
    vecs[5] = '{"zerolen",  47,  4, 0, 32'd0, 32'd0,        32'd0, 32'd0,        1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) good[i] = stim[i];

    // Reset state.
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_im_we",    32'(im_we),    32'd0);
    check("rst_im_addr",  im_addr,       32'd0);
    check("rst_im_wdata", im_wdata,      32'd0);
    check_status("rst", 1'b1, 1'b0, 1'b0);

    // Table of whole frames, each starting from where the previous left off.
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      for (int k = 0; k < vecs[v].n; k++) begin
        if (k == vecs[v].n - 1 && vecs[v].crst == 1'b0)
          check({vecs[v].name, "_core_rst_before_csum"}, 32'(core_rst), 32'd1);
        send_byte(stim[vecs[v].first + k]);
      end
      // Sampled one cycle after the last byte: covers CSUM -> core_rst latency
      // and the immediate rejection of an oversize length.
      check_status(vecs[v].name, vecs[v].crst, vecs[v].dn, vecs[v].er);
      check({vecs[v].name, "_nwrites"}, 32'(wr_addr.size()), 32'(vecs[v].exp_wr));
      if (vecs[v].exp_wr > 0 && wr_addr.size() > 0) begin
        check({vecs[v].name, "_addr0"}, wr_addr[0], vecs[v].a0);
        check({vecs[v].name, "_data0"}, wr_data[0], vecs[v].d0);
      end
      if (vecs[v].exp_wr > 1 && wr_addr.size() > 1) begin
        check({vecs[v].name, "_addr1"}, wr_addr[1], vecs[v].a1);
        check({vecs[v].name, "_data1"}, wr_data[1], vecs[v].d1);
      end
      check({vecs[v].name, "_ready_low"}, 32'(ready_low), 32'(vecs[v].exp_wr));
    end

    // Stalled data bytes: an idle cycle before every data byte.
    clear_mon();
    for (int k = 0; k < 12; k++) begin
      if (k >= 3 && k <= 10) begin
        rx_valid = 1'b0;
        @(negedge CLK);
      end
      send_byte(good[k]);
      if (k == 6 || k == 10) begin
        check($sformatf("stall_we_after_byte%0d", k), 32'(im_we), 32'd1);
        check($sformatf("stall_ready_after_byte%0d", k), 32'(rx_ready), 32'd0);
      end
    end
    check_status("stall", 1'b0, 1'b1, 1'b0);
    check("stall_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("stall_addr0", wr_addr[0], 32'd0);
      check("stall_data0", wr_data[0], 32'h20080005);
      check("stall_addr1", wr_addr[1], 32'd1);
      check("stall_data1", wr_data[1], 32'h01095020);
    end
    check("stall_ready_low", 32'(ready_low), 32'd2);

    // Reload from RUN: core goes back into reset the cycle after MAGIC.
    clear_mon();
    send_byte(8'hA5);
    check_status("reload_magic", 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) send_byte(stim[39 + k]);
    check_status("reload_end", 1'b0, 1'b1, 1'b0);
    check("reload_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) check("reload_data0", wr_data[0], 32'hAABBCCDD);

    // Reset after the 2nd data byte, then garbage in IDLE.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    clear_mon();
    check("midrst_rx_ready", 32'(rx_ready), 32'd1);
    check("midrst_im_we",    32'(im_we),    32'd0);
    check("midrst_im_addr",  im_addr,       32'd0);
    check("midrst_im_wdata", im_wdata,      32'd0);
    check_status("midrst", 1'b1, 1'b0, 1'b0);
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (3) @(negedge CLK);
    check_status("garbage", 1'b1, 1'b0, 1'b0);
    check("garbage_nwrites", 32'(wr_addr.size()), 32'd0);
    // A zero-length frame now only reaches RUN if IDLE discarded the garbage.
    for (int k = 0; k < 4; k++) send_byte(stim[47 + k]);
    check_status("after_garbage", 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
